// File: rtl/triple_burst_sender.sv
// Sends three operands to a MAC datapath on consecutive cycles, then waits for
// the result and checks it against a*b+c. The wait is bounded by a timeout.
module triple_burst_sender #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  output logic        validi,
  output logic [31:0] data_in,
  input  logic        valido,
  input  logic [31:0] data_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    SEND_C,
    WAIT
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q, c_q;
  logic [31:0] a_d, b_d, c_d;
  logic [31:0] exp_q, exp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        validi_d;
  logic [31:0] data_in_d;
  logic        done_d, err_d, timeout_d;
  logic [31:0] result_d;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    result_d  = result;
    validi_d  = 1'b0;
    data_in_d = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a_in;
          b_d       = b_in;
          c_d       = c_in;
          state_d   = SEND_A;
          validi_d  = 1'b1;
          data_in_d = a_in;
        end
      end
      SEND_A: begin
        state_d   = SEND_B;
        validi_d  = 1'b1;
        data_in_d = b_q;
        exp_d     = a_q * b_q + c_q;
      end
      SEND_B: begin
        state_d   = SEND_C;
        validi_d  = 1'b1;
        data_in_d = c_q;
      end
      SEND_C: begin
        state_d = WAIT;
        // the first WAIT cycle counts as 1
        cnt_d   = 8'd1;
      end
      WAIT: begin
        if (valido) begin
          result_d = data_out;
          done_d   = 1'b1;
          err_d    = (data_out != exp_q);
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == TO_LIM) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      validi  <= 1'b0;
      data_in <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      validi  <= validi_d;
      data_in <= data_in_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
      err     <= err_d;
      timeout <= timeout_d;
      result  <= result_d;
    end
  end

endmodule

// File: doc/triple_burst_sender.md
TRIPLE_BURST_SENDER -- requirements
Module: triple_burst_sender

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8, max WAIT cycles for valido before abort (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one transaction; sampled only in IDLE.
REQ-005 a_in, b_in, c_in  input  32 each  operands; latched on accepted start.
REQ-006 validi  output  1  valid strobe to the MAC datapath.
REQ-007 data_in  output  32  operand word to the MAC datapath.
REQ-008 valido  input  1  result valid from the MAC datapath.
REQ-009 data_out  input  32  result word from the MAC datapath.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse, result captured.
REQ-012 result  output  32  last captured data_out.
REQ-013 err  output  1  one-cycle pulse with done when captured result differs from expected.
REQ-014 timeout  output  1  one-cycle pulse, transaction aborted.

Function
REQ-015 FSM states: IDLE, SEND_A, SEND_B, SEND_C, WAIT; registered state, registered outputs.
REQ-016 IDLE: start=1 -> latch a_in/b_in/c_in, go to SEND_A; start=0 -> stay.
REQ-017 SEND_A/SEND_B/SEND_C each last exactly one cycle: validi=1, data_in = latched a/b/c respectively, then advance SEND_A->SEND_B->SEND_C->WAIT.
REQ-018 validi is high for exactly three consecutive cycles per transaction, never more, never fewer.
REQ-019 In IDLE and WAIT: validi=0, data_in=0.
REQ-020 Expected value = (a*b + c) mod 2^32, computed from latched operands, stable by entry to WAIT.
REQ-021 WAIT: 8-bit counter cleared on entry, increments each cycle; first WAIT cycle is count 1.
REQ-022 WAIT with valido=1 -> result <= data_out, done=1 next cycle, err=1 in same cycle iff data_out != expected, go to IDLE.
REQ-023 WAIT with valido=0 at count == TIMEOUT_CYCLES -> timeout=1 next cycle, result unchanged, go to IDLE.
REQ-024 valido and count==TIMEOUT_CYCLES in same cycle: valido wins (done, no timeout).
REQ-025 valido in IDLE/SEND_* ignored; no effect on result, done, err, timeout.
REQ-026 start while busy=1 ignored, not queued; operands not re-latched.
REQ-027 Back-to-back: start high in the cycle after done/timeout (state IDLE) is accepted.
REQ-028 done, err, timeout are mutually exclusive with timeout; done/err never high outside a single cycle per transaction.

Reset
REQ-029 rst_=0 asynchronously forces: state IDLE, validi=0, data_in=0, busy=0, done=0, err=0, timeout=0, result=0, counter=0, latched operands=0.
REQ-030 Reset mid-transaction (any SEND_* or WAIT) aborts immediately: validi drops without waiting for clk; no done/timeout pulse after release.
REQ-031 After rst_ deasserts, first start accepted on first posedge with start=1.

Verification
REQ-032 a=3,b=4,c=5, start pulse -> data_in 3,4,5 on three consecutive cycles with validi=1; DUT valido=1,data_out=17 next cycle -> result=17, done=1, err=0.
REQ-033 Same operands, responder returns data_out=18 -> result=18, done=1, err=1.
REQ-034 a=0xFFFFFFFF,b=2,c=3, data_out=0x00000001 -> done=1, err=0 (wrap-around).
REQ-035 No valido after SEND_C, TIMEOUT_CYCLES=8 -> timeout=1 in the cycle after 8th WAIT cycle, result holds previous value, busy=0 after.
REQ-036 rst_=0 asserted mid-SEND_B -> validi=0 and data_in=0 before the next clk edge; result=0; no done/timeout after release.
REQ-037 start held high continuously for two transactions -> exactly 6 validi cycles total, second transaction begins one cycle after first done.
